// File: rtl/button_event_decoder.sv
// Button event decoder: turns a debounced, clk-synchronous button level into
// one-cycle press / release / long-press / auto-repeat strobes plus a held level.
module button_event_decoder #(
    parameter int LONG_TICKS   = 50_000_000,
    parameter int REPEAT_TICKS = 10_000_000
) (
    input  logic       clk,
    input  logic       rst_a_p,
    input  logic       btn_in,
    input  logic       enable,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       held,
    output logic [1:0] state_out
);

    localparam int MAX_TICKS = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int CW        = $clog2(MAX_TICKS + 1);

    localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_TICKS - 1);
    localparam logic [CW-1:0] REPEAT_LAST = (REPEAT_TICKS > 0) ? CW'(REPEAT_TICKS - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_PRESSED = 2'b01,
        S_REPEAT  = 2'b10
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          btn_q;
    logic          btn_valid_q;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          repeat_q, repeat_d;
    logic          held_q, held_d;

    logic rise;
    logic fall;

    // btn_valid_q blocks a level that is already high out of reset from
    // looking like a rise: a fresh press is needed after reset.
    assign rise = btn_in & ~btn_q & btn_valid_q;
    assign fall = ~btn_in & btn_q;

    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;

        if (!enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (rise) begin
                        press_d = 1'b1;
                        state_d = S_PRESSED;
                        cnt_d   = '0;
                    end
                end
                S_PRESSED: begin
                    if (fall) begin
                        release_d = 1'b1;
                        state_d   = S_IDLE;
                        cnt_d     = '0;
                    end else if (cnt_q == LONG_LAST) begin
                        long_d  = 1'b1;
                        state_d = S_REPEAT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_REPEAT: begin
                    if (fall) begin
                        release_d = 1'b1;
                        state_d   = S_IDLE;
                        cnt_d     = '0;
                    end else if (REPEAT_TICKS != 0) begin
                        if (cnt_q == REPEAT_LAST) begin
                            repeat_d = 1'b1;
                            cnt_d    = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        held_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst_a_p) begin
        if (rst_a_p) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            btn_q       <= 1'b0;
            btn_valid_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            repeat_q    <= 1'b0;
            held_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            btn_q       <= btn_in;
            btn_valid_q <= 1'b1;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            repeat_q    <= repeat_d;
            held_q      <= held_d;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;
    assign held          = held_q;
    assign state_out     = state_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder (LONG_TICKS=8, REPEAT_TICKS=4);
// expected output vectors are queued with each stimulus step and popped after the edge.
module tb_button_event_decoder;

    logic       clk;
    logic       rst_a_p;
    logic       btn_in;
    logic       enable;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic       repeat_pulse;
    logic       held;
    logic [1:0] state_out;

    int n_cmp  = 0;
    int n_fail = 0;

    // {press, release, long, repeat, held, state[1:0]}
    logic [6:0] exp_q[$];

    button_event_decoder #(
        .LONG_TICKS  (8),
        .REPEAT_TICKS(4)
    ) dut (
        .clk          (clk),
        .rst_a_p      (rst_a_p),
        .btn_in       (btn_in),
        .enable       (enable),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .held         (held),
        .state_out    (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] ev(input logic p, input logic r, input logic l,
                                      input logic rp, input logic h, input logic [1:0] st);
        return {p, r, l, rp, h, st};
    endfunction

    function automatic logic [6:0] observed();
        return {press_pulse, release_pulse, long_pulse, repeat_pulse, held, state_out};
    endfunction

    task automatic cmp(input string tag, input logic [6:0] obs, input logic [6:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (p r l rp h st)", tag, obs, expv);
        end
    endtask

    // Drive inputs, queue the expected post-edge outputs, then pop and compare after the edge.
    task automatic step(input logic b, input logic e, input logic [6:0] expv, input string tag);
        logic [6:0] want;
        btn_in = b;
        enable = e;
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        cmp(tag, observed(), want);
    endtask

    localparam logic [6:0] ZERO = 7'b0;

    initial begin
        rst_a_p = 1'b1;
        btn_in  = 1'b0;
        enable  = 1'b1;
        #2;
        cmp("reset_state", observed(), ZERO);
        #10 rst_a_p = 1'b0;

        // Idle after reset
        step(1'b0, 1'b1, ZERO, "idle0");
        step(1'b0, 1'b1, ZERO, "idle1");

        // 1. Short press: 3 cycles high
        step(1'b1, 1'b1, ev(1, 0, 0, 0, 1, 2'b01), "short_press");
        step(1'b1, 1'b1, ev(0, 0, 0, 0, 1, 2'b01), "short_hold1");
        step(1'b1, 1'b1, ev(0, 0, 0, 0, 1, 2'b01), "short_hold2");
        step(1'b0, 1'b1, ev(0, 1, 0, 0, 0, 2'b00), "short_release");
        step(1'b0, 1'b1, ZERO, "short_after");

        // 2. Long hold: 20 cycles high
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1,
                 ev(i == 0, 0, i == 8, (i == 12) || (i == 16), 1, (i < 8) ? 2'b01 : 2'b10),
                 $sformatf("long_hold_t%0d", i));
        end
        step(1'b0, 1'b1, ev(0, 1, 0, 0, 0, 2'b00), "long_release_t20");
        step(1'b0, 1'b1, ZERO, "long_after");

        // 3. Collision: release on the long terminal edge
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, ev(i == 0, 0, 0, 0, 1, 2'b01), $sformatf("coll_hold_t%0d", i));
        end
        step(1'b0, 1'b1, ev(0, 1, 0, 0, 0, 2'b00), "coll_release_only");
        step(1'b0, 1'b1, ZERO, "coll_after");

        // 4. Enable gating
        step(1'b1, 1'b0, ZERO, "gate_dis0");
        step(1'b1, 1'b0, ZERO, "gate_dis1");
        step(1'b1, 1'b0, ZERO, "gate_dis2");
        step(1'b1, 1'b1, ZERO, "gate_en_held0");
        step(1'b1, 1'b1, ZERO, "gate_en_held1");
        step(1'b1, 1'b1, ZERO, "gate_en_held2");
        step(1'b0, 1'b1, ZERO, "gate_release_no_strobe");
        step(1'b1, 1'b1, ev(1, 0, 0, 0, 1, 2'b01), "gate_repress");
        step(1'b0, 1'b1, ev(0, 1, 0, 0, 0, 2'b00), "gate_rerelease");
        step(1'b0, 1'b1, ZERO, "gate_after");

        // 5. Drop enable in REPEAT on the edge that would have produced a repeat
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b1,
                 ev(i == 0, 0, i == 8, 0, 1, (i < 8) ? 2'b01 : 2'b10),
                 $sformatf("drop_hold_t%0d", i));
        end
        step(1'b1, 1'b0, ZERO, "drop_enable_t12");
        step(1'b0, 1'b0, ZERO, "drop_release_disabled");
        step(1'b0, 1'b1, ZERO, "drop_after");

        // 6. Asynchronous reset mid-hold
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, ev(i == 0, 0, 0, 0, 1, 2'b01), $sformatf("rst_hold_t%0d", i));
        end
        #2 rst_a_p = 1'b1;
        #1;
        cmp("rst_async_clear", observed(), ZERO);
        @(posedge clk);
        #1;
        cmp("rst_held_over_edge", observed(), ZERO);
        #2 rst_a_p = 1'b0;
        step(1'b1, 1'b1, ZERO, "rst_no_press0");
        step(1'b1, 1'b1, ZERO, "rst_no_press1");
        step(1'b1, 1'b1, ZERO, "rst_no_press2");
        step(1'b0, 1'b1, ZERO, "rst_no_release");
        step(1'b1, 1'b1, ev(1, 0, 0, 0, 1, 2'b01), "rst_fresh_press");
        step(1'b0, 1'b1, ev(0, 1, 0, 0, 0, 2'b00), "rst_fresh_release");
        step(1'b0, 1'b1, ZERO, "rst_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
